// File: rtl/scr1_imem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_imem_arb_if
//  Description : Bundle of the two requester channels (m0 fetch, m1 debug/
//                loader) and the shared imem bridge channel around
//                scr1_imem_arb. The 'slave' modport is the arbiter's view;
//                the 'master' modport is the view of the requesters and the
//                imem bridge that surround it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scr1_imem_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // fetch unit channel
   logic          m0_req;
   logic [AW-1:0] m0_addr;
   logic          m0_req_ack;
   logic [DW-1:0] m0_rdata;
   logic [1:0]    m0_resp;

   // debug / loader channel
   logic          m1_req;
   logic [AW-1:0] m1_addr;
   logic          m1_req_ack;
   logic [DW-1:0] m1_rdata;
   logic [1:0]    m1_resp;

   // shared imem bridge channel
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_req_ack;
   logic [DW-1:0] imem_rdata;
   logic [1:0]    imem_resp;

   // arbiter side
   modport slave (
      input  m0_req, m0_addr,
      output m0_req_ack, m0_rdata, m0_resp,
      input  m1_req, m1_addr,
      output m1_req_ack, m1_rdata, m1_resp,
      output imem_req, imem_addr,
      input  imem_req_ack, imem_rdata, imem_resp
   );

   // requesters and imem bridge side
   modport master (
      output m0_req, m0_addr,
      input  m0_req_ack, m0_rdata, m0_resp,
      output m1_req, m1_addr,
      input  m1_req_ack, m1_rdata, m1_resp,
      input  imem_req, imem_addr,
      output imem_req_ack, imem_rdata, imem_resp
   );
endinterface
`default_nettype wire

// File: rtl/scr1_imem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_imem_arb
//  Description : Two-requester round-robin arbiter for the SCR1 imem port.
//                Grants m0/m1 onto the single imem request channel, holds a
//                pending request locked until the bridge accepts it, records
//                the issuing master of every accepted request in an order
//                FIFO and steers each response back to that master.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_imem_arb #(
   parameter int OUTST_DEPTH = 2,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   scr1_imem_arb_if.slave       bus,
   output logic                 arb_err
);

   localparam int              c_ptr_w    = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int              c_cnt_w    = $clog2(OUTST_DEPTH + 1);
   localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(OUTST_DEPTH - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(OUTST_DEPTH);

   // master identifiers stored in the order FIFO
   localparam logic c_id_m0 = 1'b0;
   localparam logic c_id_m1 = 1'b1;

   // order FIFO of issuing-master IDs
   logic                 r_fifo [OUTST_DEPTH];
   logic [c_ptr_w-1:0]   r_wptr;
   logic [c_ptr_w-1:0]   r_rptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 r_full;

   // grant history and lock
   logic                 r_last_grant;
   logic                 r_lock;
   logic                 r_lock_id;
   logic                 r_arb_err;

   logic                 w_grant_vld;
   logic                 w_grant_id;
   logic                 w_sel_req;
   logic                 w_imem_req;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic                 w_head;
   logic                 w_resp_vld;
   logic [1:0]           w_resp_code;
   logic [c_cnt_w-1:0]   w_count_nxt;

   // Grant selection: a locked grant wins; otherwise single requester or
   // the master that was not granted last. Nothing is granted when full.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_id  = c_id_m0;
      if (r_lock) begin
         w_grant_vld = 1'b1;
         w_grant_id  = r_lock_id;
      end else if (!r_full) begin
         if (bus.m0_req && bus.m1_req) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_grant;
         end else if (bus.m0_req) begin
            w_grant_vld = 1'b1;
            w_grant_id  = c_id_m0;
         end else if (bus.m1_req) begin
            w_grant_vld = 1'b1;
            w_grant_id  = c_id_m1;
         end
      end
   end

   // request channel towards the bridge; acks return in the same cycle
   assign w_sel_req        = (w_grant_id == c_id_m1) ? bus.m1_req : bus.m0_req;
   assign w_imem_req       = w_grant_vld & w_sel_req & ~r_full;
   assign bus.imem_req     = w_imem_req;
   assign bus.imem_addr    = (w_grant_vld && (w_grant_id == c_id_m1)) ? bus.m1_addr : bus.m0_addr;
   assign w_push           = w_imem_req & bus.imem_req_ack;
   assign bus.m0_req_ack   = w_push & (w_grant_id == c_id_m0);
   assign bus.m1_req_ack   = w_push & (w_grant_id == c_id_m1);

   // response side: the reserved code 11 is reported to the master as an error
   assign w_resp_vld  = |bus.imem_resp;
   assign w_resp_code = (bus.imem_resp == 2'b11) ? 2'b10 : bus.imem_resp;
   assign w_empty     = (r_count == '0);
   assign w_pop       = w_resp_vld & ~w_empty;
   assign w_head      = r_fifo[r_rptr];

   assign bus.m0_resp  = (w_pop && (w_head == c_id_m0)) ? w_resp_code    : 2'b00;
   assign bus.m0_rdata = (w_pop && (w_head == c_id_m0)) ? bus.imem_rdata : '0;
   assign bus.m1_resp  = (w_pop && (w_head == c_id_m1)) ? w_resp_code    : 2'b00;
   assign bus.m1_rdata = (w_pop && (w_head == c_id_m1)) ? bus.imem_rdata : '0;

   assign arb_err = r_arb_err;

   // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
         2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Order FIFO storage, pointers and registered full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUTST_DEPTH; i++) begin
            r_fifo[i] <= c_id_m0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_grant_id;
            r_wptr         <= (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_w'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_cnt_full);
      end
   end

   // Grant history and lock: an offered but unaccepted request freezes the
   // grant; dropping the request releases it because imem_req falls to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= c_id_m1;
         r_lock       <= 1'b0;
         r_lock_id    <= c_id_m0;
      end else begin
         r_lock <= w_imem_req & ~bus.imem_req_ack;
         if (w_imem_req) begin
            r_lock_id <= w_grant_id;
         end
         if (w_push) begin
            r_last_grant <= w_grant_id;
         end
      end
   end

   // Sticky flag for a response arriving with nothing outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arb_err <= 1'b0;
      end else if (w_resp_vld && w_empty) begin
         r_arb_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scr1_imem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_imem_arb
//  Description : Directed self-checking bench for scr1_imem_arb
//                (OUTST_DEPTH=2, AW=DW=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_imem_arb;

   logic clk;
   logic rst_n;
   logic arb_err;
   int   n_checks;
   int   n_errors;

   scr1_imem_arb_if #(.AW(32), .DW(32)) bus ();

   scr1_imem_arb #(.OUTST_DEPTH(2), .AW(32), .DW(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .arb_err (arb_err)
   );

   // free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.m0_req       = 1'b0;
      bus.m1_req       = 1'b0;
      bus.imem_req_ack = 1'b0;
      bus.imem_resp    = 2'b00;
      bus.imem_rdata   = '0;
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_imem_req"}, bus.imem_req,   1'b0);
      chk({tag, "_m0_ack"},   bus.m0_req_ack, 1'b0);
      chk({tag, "_m1_ack"},   bus.m1_req_ack, 1'b0);
      chk({tag, "_m0_resp"},  bus.m0_resp,    2'b00);
      chk({tag, "_m1_resp"},  bus.m1_resp,    2'b00);
      chk({tag, "_m0_rdata"}, bus.m0_rdata,   32'h0);
      chk({tag, "_m1_rdata"}, bus.m1_rdata,   32'h0);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      bus.m0_addr  = 32'h0;
      bus.m1_addr  = 32'h0;
      idle();
      rst_n = 1'b0;
      #12;
      // ---------------- reset state
      chk_quiet("rst");
      chk("rst_arb_err", arb_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- T1: single fetch, response two cycles later
      bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.imem_req_ack = 1'b1;
      #1;
      chk("t1_imem_req",  bus.imem_req,   1'b1);
      chk("t1_imem_addr", bus.imem_addr,  32'h100);
      chk("t1_m0_ack",    bus.m0_req_ack, 1'b1);
      chk("t1_m1_ack",    bus.m1_req_ack, 1'b0);
      tick();
      idle();
      tick();
      bus.imem_resp = 2'b01; bus.imem_rdata = 32'hA5A5;
      #1;
      chk("t1_m0_resp",  bus.m0_resp,  2'b01);
      chk("t1_m0_rdata", bus.m0_rdata, 32'hA5A5);
      chk("t1_m1_resp",  bus.m1_resp,  2'b00);
      chk("t1_m1_rdata", bus.m1_rdata, 32'h0);
      tick();
      idle();

      // ---------------- T2: both request every cycle, alternation m0,m1,m0,m1
      do_reset();
      bus.m0_addr = 32'h200; bus.m1_addr = 32'h300;
      for (int k = 0; k < 5; k++) begin
         bus.m0_req       = (k < 4);
         bus.m1_req       = (k < 4);
         bus.imem_req_ack = (k < 4);
         bus.imem_resp    = (k > 0) ? 2'b01 : 2'b00;
         bus.imem_rdata   = (k > 0) ? (32'h1000 + 32'(k)) : 32'h0;
         #1;
         if (k < 4) begin
            chk("t2_m0_ack",    bus.m0_req_ack, (k % 2) == 0);
            chk("t2_m1_ack",    bus.m1_req_ack, (k % 2) == 1);
            chk("t2_imem_addr", bus.imem_addr,  ((k % 2) == 0) ? 32'h200 : 32'h300);
         end
         if (k > 0) begin
            if (((k - 1) % 2) == 0) begin
               chk("t2_m0_resp",  bus.m0_resp,  2'b01);
               chk("t2_m0_rdata", bus.m0_rdata, 32'h1000 + 32'(k));
               chk("t2_m1_resp",  bus.m1_resp,  2'b00);
            end else begin
               chk("t2_m1_resp",  bus.m1_resp,  2'b01);
               chk("t2_m1_rdata", bus.m1_rdata, 32'h1000 + 32'(k));
               chk("t2_m0_resp",  bus.m0_resp,  2'b00);
            end
         end
         tick();
      end
      idle();

      // ---------------- T3: fill the FIFO, stall, then drain
      bus.m0_req = 1'b1; bus.m0_addr = 32'h600; bus.imem_req_ack = 1'b1;
      #1;
      chk("t3_acc0_m0_ack", bus.m0_req_ack, 1'b1);
      tick();
      bus.m0_req = 1'b0; bus.m1_req = 1'b1; bus.m1_addr = 32'h700;
      #1;
      chk("t3_acc1_m1_ack", bus.m1_req_ack, 1'b1);
      tick();
      bus.m1_req = 1'b0; bus.m0_req = 1'b1;
      #1;
      chk("t3_full_imem_req", bus.imem_req,   1'b0);
      chk("t3_full_m0_ack",   bus.m0_req_ack, 1'b0);
      tick();
      bus.imem_req_ack = 1'b0; bus.imem_resp = 2'b10; bus.imem_rdata = 32'hBAD;
      #1;
      chk("t3_r0_m0_resp",   bus.m0_resp,  2'b10);
      chk("t3_r0_m0_rdata",  bus.m0_rdata, 32'hBAD);
      chk("t3_r0_m1_resp",   bus.m1_resp,  2'b00);
      chk("t3_r0_imem_req",  bus.imem_req, 1'b0);
      tick();
      bus.imem_resp = 2'b01; bus.imem_rdata = 32'h600D;
      #1;
      chk("t3_r1_m1_resp",   bus.m1_resp,  2'b01);
      chk("t3_r1_m1_rdata",  bus.m1_rdata, 32'h600D);
      chk("t3_r1_m0_resp",   bus.m0_resp,  2'b00);
      chk("t3_r1_imem_req",  bus.imem_req, 1'b1);
      tick();
      idle();
      tick();

      // ---------------- T4: lock holds m1 against a competing m0
      bus.m1_req = 1'b1; bus.m1_addr = 32'h400;
      #1;
      chk("t4_c1_imem_req",  bus.imem_req,   1'b1);
      chk("t4_c1_imem_addr", bus.imem_addr,  32'h400);
      chk("t4_c1_m1_ack",    bus.m1_req_ack, 1'b0);
      tick();
      bus.m0_req = 1'b1; bus.m0_addr = 32'h500;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("t4_lock_imem_addr", bus.imem_addr,  32'h400);
         chk("t4_lock_m0_ack",    bus.m0_req_ack, 1'b0);
         tick();
      end
      bus.imem_req_ack = 1'b1;
      #1;
      chk("t4_acc_m1_ack",    bus.m1_req_ack, 1'b1);
      chk("t4_acc_m0_ack",    bus.m0_req_ack, 1'b0);
      chk("t4_acc_imem_addr", bus.imem_addr,  32'h400);
      tick();
      bus.m1_req = 1'b0;
      #1;
      chk("t4_m0_ack",       bus.m0_req_ack, 1'b1);
      chk("t4_m0_imem_addr", bus.imem_addr,  32'h500);
      tick();
      idle();
      bus.imem_resp = 2'b11; bus.imem_rdata = 32'h11;
      #1;
      chk("t4_r11_m1_resp",  bus.m1_resp,  2'b10);
      chk("t4_r11_m1_rdata", bus.m1_rdata, 32'h11);
      chk("t4_r11_m0_resp",  bus.m0_resp,  2'b00);
      tick();
      bus.imem_resp = 2'b01; bus.imem_rdata = 32'h22;
      #1;
      chk("t4_r_m0_resp",  bus.m0_resp,  2'b01);
      chk("t4_r_m0_rdata", bus.m0_rdata, 32'h22);
      tick();
      idle();
      chk("t4_arb_err", arb_err, 1'b0);

      // ---------------- T5: orphan response sets sticky arb_err
      bus.imem_resp = 2'b01; bus.imem_rdata = 32'h33;
      #1;
      chk("t5_m0_resp",  bus.m0_resp,  2'b00);
      chk("t5_m1_resp",  bus.m1_resp,  2'b00);
      chk("t5_m0_rdata", bus.m0_rdata, 32'h0);
      tick();
      idle();
      chk("t5_err_set", arb_err, 1'b1);
      tick();
      tick();
      chk("t5_err_held", arb_err, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_err_clr", arb_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- T6: reset with two outstanding
      bus.m0_req = 1'b1; bus.m0_addr = 32'h800; bus.imem_req_ack = 1'b1;
      tick();
      bus.m0_req = 1'b0; bus.m1_req = 1'b1; bus.m1_addr = 32'h900;
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      chk_quiet("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.imem_resp = 2'b01; bus.imem_rdata = 32'h44;
      #1;
      chk("t6_empty_m0_resp", bus.m0_resp, 2'b00);
      chk("t6_empty_m1_resp", bus.m1_resp, 2'b00);
      tick();
      idle();
      bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.imem_req_ack = 1'b1;
      #1;
      chk("t6_tie_m0_ack",    bus.m0_req_ack, 1'b1);
      chk("t6_tie_m1_ack",    bus.m1_req_ack, 1'b0);
      chk("t6_tie_imem_addr", bus.imem_addr,  32'h800);
      tick();
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
